aes_key_expand: RTL and testbench



---
 rtl/aes_pkg.sv | 34 +++
 rtl/sbox.sv | 45 ++++
 rtl/sub_word.sv | 31 +++
 rtl/aes_key_expand.sv | 104 ++++++++++
 tb/tb_aes_key_expand.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-expansion engine.
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned SBOX_LATENCY = 5;
  localparam int unsigned NR           = 10;

  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StWait  = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/sbox.sv
// AES S-box with a fixed SBOX_LATENCY-cycle pipeline; the substitution itself is computed
// arithmetically (GF(2^8) inverse followed by the affine map) in the first stage.
module sbox
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  input  logic [7:0] in_byte_i,
  output logic       out_valid_o,
  output logic [7:0] out_byte_o
);

  // x^254 == x^-1 in GF(2^8), and 0 maps to 0.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [SBOX_LATENCY-1:0] vld_q;
  logic [7:0]              dat_q [SBOX_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(SBOX_LATENCY); i++) dat_q[i] <= '0;
    end else begin
      vld_q    <= {vld_q[SBOX_LATENCY-2:0], in_valid_i};
      dat_q[0] <= sub_byte(in_byte_i);
      for (int i = 1; i < int'(SBOX_LATENCY); i++) dat_q[i] <= dat_q[i-1];
    end
  end

  assign out_valid_o = vld_q[SBOX_LATENCY-1];
  assign out_byte_o  = dat_q[SBOX_LATENCY-1];

endmodule

// File: rtl/sub_word.sv
// SubWord: four pipelined S-boxes sharing one valid; out_valid follows the byte-0 lane.
module sub_word
  import aes_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid_i,
  input  word_t in_word_i,
  output logic  out_valid_o,
  output word_t out_word_o
);

  logic [3:0] lane_vld;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    sbox u_sbox (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (in_valid_i),
      .in_byte_i  (in_word_i[8*b +: 8]),
      .out_valid_o(lane_vld[b]),
      .out_byte_o (out_word_o[8*b +: 8])
    );
  end

  // Byte 0 lives in [31:24]; the other lanes must track it exactly.
  assign out_valid_o = lane_vld[3];

  assert property (@(posedge clk) disable iff (rst) lane_vld == {4{lane_vld[3]}});

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: accepts a key on start/ready and streams round keys 0..10,
// pacing each round on the SubWord pipeline's out_valid.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         ready,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk
);

  localparam logic [3:0] LastRound = 4'(NR);

  state_t     state_q, state_d;
  word_t      w_q [4];
  word_t      w_d [4];
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;

  logic  sw_valid;
  logic  sw_out_valid;
  word_t sw_in;
  word_t sw_out;
  word_t t;

  assign sw_in = {w_q[3][23:0], w_q[3][31:24]};

  sub_word u_sub_word (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (sw_valid),
    .in_word_i  (sw_in),
    .out_valid_o(sw_out_valid),
    .out_word_o (sw_out)
  );

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    round_d  = round_q;
    rcon_d   = rcon_q;
    sw_valid = 1'b0;
    t        = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          w_d[0]  = key[127:96];
          w_d[1]  = key[95:64];
          w_d[2]  = key[63:32];
          w_d[3]  = key[31:0];
          round_d = 4'd0;
          rcon_d  = 8'h01;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (round_q == LastRound) begin
          state_d = StIdle;
        end else begin
          sw_valid = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (sw_out_valid) begin
          t       = sw_out ^ {rcon_q, 24'h0};
          w_d[0]  = w_q[0] ^ t;
          w_d[1]  = w_q[1] ^ w_d[0];
          w_d[2]  = w_q[2] ^ w_d[1];
          w_d[3]  = w_q[3] ^ w_d[2];
          round_d = round_q + 4'd1;
          rcon_d  = xtime(rcon_q);
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      for (int i = 0; i < 4; i++) w_q[i] <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // w only changes on entry to ISSUE, so rk naturally holds between pulses.
  assign ready    = (state_q == StIdle);
  assign rk_valid = (state_q == StIssue);
  assign rk_idx   = round_q;
  assign rk       = {w_q[0], w_q[1], w_q[2], w_q[3]};

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors plus random keys against a table-driven model.
module tb_aes_key_expand;

  typedef logic [127:0] rk_arr_t [11];

  localparam logic [127:0] KeyA1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1Rk1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1Rk10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroRk1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZeroRk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  localparam logic [0:9][7:0] Rc = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         ready;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0]   cap_idx [$];
  logic [127:0] cap_rk  [$];
  int           cap_cyc [$];
  logic         rdy_log [0:199];
  logic [7:0]   rcon8;
  logic [7:0]   rcon9;

  aes_key_expand dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key     (key),
    .ready   (ready),
    .rk_valid(rk_valid),
    .rk_idx  (rk_idx),
    .rk      (rk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sub_w(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // Textbook FIPS-197 word recurrence over all 44 words.
  task automatic model_expand(input logic [127:0] k, output rk_arr_t r);
    logic [31:0] w [44];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = sub_w({tmp[23:0], tmp[31:24]}) ^ {Rc[i/4-1], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // Starts a run in cycle T, then steps ncyc cycles logging ready and every rk_valid pulse
  // with its cycle offset from T. Optional extra start (inj_at) and reset (rst_at) pulses.
  task automatic run_capture(input logic [127:0] k, input int ncyc, input int inj_at,
                             input logic [127:0] inj_key, input int rst_at);
    cap_idx.delete();
    cap_rk.delete();
    cap_cyc.delete();
    rcon8 = 8'hxx;
    rcon9 = 8'hxx;
    @(posedge clk); #1;
    key   = k;
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = 1'b0;
      if (c == inj_at) begin
        start = 1'b1;
        key   = inj_key;
      end
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      rdy_log[c] = ready;
      if (rk_valid) begin
        cap_idx.push_back(rk_idx);
        cap_rk.push_back(rk);
        cap_cyc.push_back(c);
        if (rk_idx == 4'd8) rcon8 = dut.rcon_q;
        if (rk_idx == 4'd9) rcon9 = dut.rcon_q;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) $display("FAIL reset_ready: got %b, expected 1", ready);
    else n_pass++;
    n_checks++;
    if (rk_valid !== 1'b0) $display("FAIL reset_rk_valid: got %b, expected 0", rk_valid);
    else n_pass++;
    n_checks++;
    if (rk_idx !== 4'd0) $display("FAIL reset_rk_idx: got %0d, expected 0", rk_idx);
    else n_pass++;
    n_checks++;
    if (rk !== 128'h0) $display("FAIL reset_rk: got %h, expected 0", rk);
    else n_pass++;
    n_checks++;
    if (dut.rcon_q !== 8'h01) $display("FAIL reset_rcon: got %h, expected 01", dut.rcon_q);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fips_a1();
    rk_arr_t exp;
    int      highs;
    model_expand(KeyA1, exp);
    run_capture(KeyA1, 64, 0, '0, 0);
    n_checks++;
    if (cap_rk.size() != 11) $display("FAIL a1_count: got %0d, expected 11", cap_rk.size());
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (i >= cap_rk.size() || cap_rk[i] !== exp[i] || cap_idx[i] !== 4'(i) ||
          cap_cyc[i] != 1 + 6 * i)
        $display("FAIL a1_rk%0d: got %h idx %0d at T+%0d, expected %h idx %0d at T+%0d", i,
                 (i < cap_rk.size()) ? cap_rk[i] : 128'hx, (i < cap_rk.size()) ? cap_idx[i] : 0,
                 (i < cap_rk.size()) ? cap_cyc[i] : -1, exp[i], i, 1 + 6 * i);
      else n_pass++;
    end
    n_checks++;
    if (cap_rk.size() < 11 || cap_rk[0] !== KeyA1 || cap_rk[1] !== A1Rk1 ||
        cap_rk[10] !== A1Rk10)
      $display("FAIL a1_vectors: got rk1 %h rk10 %h, expected %h %h",
               (cap_rk.size() > 1) ? cap_rk[1] : 128'hx, (cap_rk.size() > 10) ? cap_rk[10] : 128'hx,
               A1Rk1, A1Rk10);
    else n_pass++;
    highs = 0;
    for (int c = 1; c <= 61; c++) if (rdy_log[c] !== 1'b0) highs++;
    n_checks++;
    if (highs != 0) $display("FAIL a1_ready_low: got %0d high cycles, expected 0", highs);
    else n_pass++;
    n_checks++;
    if (rdy_log[62] !== 1'b1) $display("FAIL a1_ready_t62: got %b, expected 1", rdy_log[62]);
    else n_pass++;
    n_checks++;
    if (rcon8 !== 8'h1b || rcon9 !== 8'h36)
      $display("FAIL rcon_wrap: got %h/%h, expected 1b/36", rcon8, rcon9);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    rk_arr_t exp;
    model_expand(KeyA1, exp);
    run_capture(KeyA1, 64, 20, 128'h00112233445566778899aabbccddeeff, 0);
    n_checks++;
    if (cap_rk.size() != 11) $display("FAIL ign_count: got %0d, expected 11", cap_rk.size());
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (i >= cap_rk.size() || cap_rk[i] !== exp[i] || cap_cyc[i] != 1 + 6 * i)
        $display("FAIL ign_rk%0d: got %h, expected %h at T+%0d", i,
                 (i < cap_rk.size()) ? cap_rk[i] : 128'hx, exp[i], 1 + 6 * i);
      else n_pass++;
    end
  endtask

  task automatic test_zero_key();
    run_capture('0, 64, 0, '0, 0);
    n_checks++;
    if (cap_rk.size() != 11) $display("FAIL zero_count: got %0d, expected 11", cap_rk.size());
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (i >= cap_idx.size() || cap_idx[i] !== 4'(i))
        $display("FAIL zero_idx%0d: got %0d, expected %0d", i,
                 (i < cap_idx.size()) ? cap_idx[i] : 4'hx, i);
      else n_pass++;
    end
    n_checks++;
    if (cap_rk.size() < 11 || cap_rk[1] !== ZeroRk1 || cap_rk[10] !== ZeroRk10)
      $display("FAIL zero_vectors: got rk1 %h rk10 %h, expected %h %h",
               (cap_rk.size() > 1) ? cap_rk[1] : 128'hx, (cap_rk.size() > 10) ? cap_rk[10] : 128'hx,
               ZeroRk1, ZeroRk10);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    rk_arr_t exp;
    int      late;
    model_expand(KeyA1, exp);
    run_capture(KeyA1, 40, 0, '0, 25);
    n_checks++;
    if (rdy_log[26] !== 1'b1) $display("FAIL rst_ready: got %b, expected 1", rdy_log[26]);
    else n_pass++;
    late = 0;
    foreach (cap_cyc[j]) if (cap_cyc[j] >= 26) late++;
    n_checks++;
    if (late != 0) $display("FAIL rst_no_pulse: got %0d late pulses, expected 0", late);
    else n_pass++;
    n_checks++;
    if (cap_rk.size() != 5) $display("FAIL rst_count: got %0d, expected 5", cap_rk.size());
    else n_pass++;
    run_capture(KeyA1, 64, 0, '0, 0);
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (i >= cap_rk.size() || cap_rk[i] !== exp[i] || cap_cyc[i] != 1 + 6 * i)
        $display("FAIL restart_rk%0d: got %h, expected %h at T+%0d", i,
                 (i < cap_rk.size()) ? cap_rk[i] : 128'hx, exp[i], 1 + 6 * i);
      else n_pass++;
    end
    n_checks++;
    if (cap_rk.size() != 11) $display("FAIL restart_count: got %0d, expected 11", cap_rk.size());
    else n_pass++;
  endtask

  task automatic test_random();
    rk_arr_t      exp;
    logic [127:0] k;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k, exp);
      run_capture(k, 64, 0, '0, 0);
      for (int i = 0; i < 11; i++) begin
        n_checks++;
        if (i >= cap_rk.size() || cap_rk[i] !== exp[i] || cap_cyc[i] != 1 + 6 * i)
          $display("FAIL rand%0d_rk%0d: got %h, expected %h (key %h)", n, i,
                   (i < cap_rk.size()) ? cap_rk[i] : 128'hx, exp[i], k);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    rk_arr_t exp;
    model_expand('0, exp);
    run_capture(KeyA1, 130, 62, '0, 0);
    n_checks++;
    if (cap_rk.size() != 22) $display("FAIL b2b_count: got %0d, expected 22", cap_rk.size());
    else n_pass++;
    n_checks++;
    if (cap_rk.size() < 13 || cap_cyc[11] != 63 || cap_idx[11] !== 4'd0 || cap_rk[11] !== '0)
      $display("FAIL b2b_rk0: got T+%0d %h, expected T+63 0",
               (cap_rk.size() > 11) ? cap_cyc[11] : -1, (cap_rk.size() > 11) ? cap_rk[11] : 128'hx);
    else n_pass++;
    n_checks++;
    if (cap_rk.size() < 13 || cap_cyc[12] != 69 || cap_rk[12] !== ZeroRk1)
      $display("FAIL b2b_rk1: got T+%0d %h, expected T+69 %h",
               (cap_rk.size() > 12) ? cap_cyc[12] : -1, (cap_rk.size() > 12) ? cap_rk[12] : 128'hx,
               ZeroRk1);
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (11 + i >= cap_rk.size() || cap_rk[11+i] !== exp[i] || cap_cyc[11+i] != 63 + 6 * i)
        $display("FAIL b2b_second_rk%0d: got %h, expected %h at T+%0d", i,
                 (11 + i < cap_rk.size()) ? cap_rk[11+i] : 128'hx, exp[i], 63 + 6 * i);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fips_a1();
    test_start_ignored();
    test_zero_key();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
